// File: rtl/fastbconv_q_to_bba_seq_pkg.sv
// rtl/fastbconv_q_to_bba_seq_pkg.sv - bases, precomputed CRT constants and types for the q -> B∪Ba converter
package fastbconv_q_to_bba_seq_pkg;

  localparam int RNS_PRIME_BITS = 5;
  localparam int N_SLOTS        = 2;
  localparam int Q_BASIS_LEN    = 3;
  localparam int BBA_BASIS_LEN  = 4;
  localparam int IDX_BITS       = (Q_BASIS_LEN > 1) ? $clog2(Q_BASIS_LEN) : 1;

  typedef logic [RNS_PRIME_BITS-1:0]   rns_residue_t;
  typedef logic [2*RNS_PRIME_BITS-1:0] wide_rns_residue_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // q = 7*11*13 = 1001; B first (17, 19), then Ba (23, 29)
  localparam rns_residue_t Q_BASIS   [Q_BASIS_LEN]   = '{5'd7, 5'd11, 5'd13};
  localparam rns_residue_t BBA_BASIS [BBA_BASIS_LEN] = '{5'd17, 5'd19, 5'd23, 5'd29};

  // z_i = (q/q_i)^-1 mod q_i ; y_ij = (q/q_i) mod m_j
  localparam rns_residue_t Z_MOD_Q [Q_BASIS_LEN] = '{5'd5, 5'd4, 5'd12};
  localparam rns_residue_t Y_Q_TO_BBA [Q_BASIS_LEN][BBA_BASIS_LEN] = '{
    '{5'd7, 5'd10, 5'd5,  5'd27},
    '{5'd6, 5'd15, 5'd22, 5'd4},
    '{5'd9, 5'd1,  5'd8,  5'd19}
  };

endpackage

// File: rtl/fastbconv_q_to_bba_seq_modadd_mulmod.sv
// rtl/fastbconv_q_to_bba_seq_modadd_mulmod.sv - one (slot, modulus) lane: (a + b*c mod m) mod m
module fastbconv_q_to_bba_seq_modadd_mulmod
  import fastbconv_q_to_bba_seq_pkg::*;
#(
  parameter rns_residue_t M = 5'd17
) (
  input  rns_residue_t a,
  input  rns_residue_t b,
  input  rns_residue_t c,
  output rns_residue_t sum
);

  wide_rns_residue_t         prod;
  rns_residue_t              prod_red;
  logic [RNS_PRIME_BITS:0]   add_raw;
  logic [RNS_PRIME_BITS:0]   add_sub;

  // a < M and prod_red < M, so one conditional subtract restores the range
  always_comb begin
    prod     = wide_rns_residue_t'(b) * wide_rns_residue_t'(c);
    prod_red = rns_residue_t'(prod % wide_rns_residue_t'(M));
    add_raw  = {1'b0, a} + {1'b0, prod_red};
    add_sub  = add_raw - {1'b0, M};
    sum      = (add_raw >= {1'b0, M}) ? add_sub[RNS_PRIME_BITS-1:0] : add_raw[RNS_PRIME_BITS-1:0];
  end

endmodule

// File: rtl/fastbconv_q_to_bba_seq.sv
// rtl/fastbconv_q_to_bba_seq.sv - sequential fast base conversion q -> B∪Ba, one q residue folded per cycle
// Optional macro FBC_Q2BBA_BACKPRESSURE_EN: DONE holds out_valid until out_ready.
module fastbconv_q_to_bba_seq
  import fastbconv_q_to_bba_seq_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [N_SLOTS-1:0][Q_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0]   input_RNSpoly,
  output logic out_valid,
  input  logic out_ready,
  output logic [N_SLOTS-1:0][BBA_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0] output_RNSpoly
);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_BITS-1:0] idx;
  logic                last;
  logic [N_SLOTS-1:0][Q_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0]   x_lat;
  logic [N_SLOTS-1:0][BBA_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0] acc;
  logic [N_SLOTS-1:0][BBA_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0] acc_nxt;
  logic [N_SLOTS-1:0][BBA_BASIS_LEN-1:0][RNS_PRIME_BITS-1:0] out_data;
  rns_residue_t        scaled [N_SLOTS];

  assign last = (idx == IDX_BITS'(Q_BASIS_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_RUN;
      ST_RUN:  if (last) state_nxt = ST_DONE;
`ifdef FBC_Q2BBA_BACKPRESSURE_EN
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
`else
      ST_DONE: state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

`ifndef FBC_Q2BBA_BACKPRESSURE_EN
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
`endif

  // out_data is loaded with the final sum so it only changes at entry to DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      x_lat    <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          x_lat <= input_RNSpoly;
          acc   <= '0;
          idx   <= '0;
        end
        ST_RUN: begin
          acc <= acc_nxt;
          if (last) out_data <= acc_nxt;
          else      idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign output_RNSpoly = out_data;

  // the scale step x*z mod q_idx is shared by every BBa lane of a slot
  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    rns_residue_t scaled_i [Q_BASIS_LEN];
    for (genvar i = 0; i < Q_BASIS_LEN; i++) begin : g_q
      assign scaled_i[i] = rns_residue_t'((wide_rns_residue_t'(x_lat[k][i]) * wide_rns_residue_t'(Z_MOD_Q[i]))
                                          % wide_rns_residue_t'(Q_BASIS[i]));
    end
    assign scaled[k] = scaled_i[idx];

    for (genvar j = 0; j < BBA_BASIS_LEN; j++) begin : g_m
      fastbconv_q_to_bba_seq_modadd_mulmod #(
        .M (BBA_BASIS[j])
      ) u_lane (
        .a   (acc[k][j]),
        .b   (scaled[k]),
        .c   (Y_Q_TO_BBA[idx][j]),
        .sum (acc_nxt[k][j])
      );
    end
  end

endmodule

// File: tb/tb_fastbconv_q_to_bba_seq.sv
// tb/tb_fastbconv_q_to_bba_seq.sv - scoreboard bench for fastbconv_q_to_bba_seq
module tb_fastbconv_q_to_bba_seq;
  import fastbconv_q_to_bba_seq_pkg::*;

  localparam int NS = N_SLOTS;
  localparam int QL = Q_BASIS_LEN;
  localparam int BL = BBA_BASIS_LEN;
  localparam int W  = RNS_PRIME_BITS;

  typedef logic [NS-1:0][QL-1:0][W-1:0] in_t;
  typedef logic [NS-1:0][BL-1:0][W-1:0] out_t;

  int tq [QL] = '{7, 11, 13};
  int tm [BL] = '{17, 19, 23, 29};

  logic clk = 1'b0;
  logic reset_n, in_valid, in_ready, out_valid, out_ready;
  in_t  in_poly;
  out_t out_poly;

  int total = 0;
  int bad   = 0;
  out_t exp_q [$];

  fastbconv_q_to_bba_seq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .input_RNSpoly  (in_poly),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .output_RNSpoly (out_poly)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int inv_mod(int a, int m);
    for (int v = 1; v < m; v++) if ((a * v) % m == 1) return v;
    return 0;
  endfunction

  function automatic out_t model(in_t x);
    out_t r;
    int qq, qi, z, s;
    qq = 1;
    for (int i = 0; i < QL; i++) qq *= tq[i];
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < BL; j++) begin
        s = 0;
        for (int i = 0; i < QL; i++) begin
          qi = qq / tq[i];
          z  = inv_mod(qi % tq[i], tq[i]);
          s += ((int'(x[k][i]) * z) % tq[i]) * (qi % tm[j]);
        end
        r[k][j] = W'(s % tm[j]);
      end
    return r;
  endfunction

  // scoreboard pop on every accepted output
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        out_t e;
        logic in_range;
        e = exp_q.pop_front();
        check("out_poly", out_poly, e);
        in_range = 1'b1;
        for (int k = 0; k < NS; k++)
          for (int j = 0; j < BL; j++)
            if (int'(out_poly[k][j]) >= tm[j]) in_range = 1'b0;
        check("out_range", in_range, 1);
      end
    end
  end

  task automatic send(input in_t p);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_poly  = p;
    in_valid = 1'b1;
    exp_q.push_back(model(p));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // leaves the bench at the first DONE negedge; reports latency and in_ready-low count
  task automatic send_wait(input in_t p, input logic chk_timing);
    int lat, low;
    send(p);
    lat = 1;
    low = 0;
    while (!out_valid && lat < 64) begin
      if (!in_ready) low++;
      lat++;
      @(negedge clk);
    end
    if (!in_ready) low++;
    if (chk_timing) begin
      check("latency", lat, QL + 1);
      check("in_ready_low", low, QL + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t p;
    int  nov, cyc, last_acc, nacc;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_poly   = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_poly", out_poly, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // all-zero poly with timing checks
    p = '0;
    send_wait(p, 1'b1);
    @(negedge clk);

    // unit residue at i=0
    p = '0;
    for (int k = 0; k < NS; k++) p[k][0] = W'(1);
    send_wait(p, 1'b1);
    @(negedge clk);

    // value 5+k in every residue
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < QL; i++) p[k][i] = W'((5 + k) % tq[i]);
    send_wait(p, 1'b0);
    @(negedge clk);

    // max residues q_i-1
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < QL; i++) p[k][i] = W'(tq[i] - 1);
    send_wait(p, 1'b0);
    @(negedge clk);

    // a few random polys
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NS; k++)
        for (int i = 0; i < QL; i++) p[k][i] = W'($urandom_range(0, tq[i] - 1));
      send_wait(p, 1'b0);
      @(negedge clk);
    end

    // abort at RUN idx=1: no output for that poly
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < QL; i++) p[k][i] = W'($urandom_range(0, tq[i] - 1));
    in_poly  = p;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    nov = 0;
    repeat (QL + 3) begin
      @(negedge clk);
      if (out_valid) nov++;
    end
    check("abort_no_valid", nov, 0);
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < QL; i++) p[k][i] = W'((3 * k + i + 1) % tq[i]);
    send_wait(p, 1'b1);
    @(negedge clk);

    // in_valid held high: one accept every QL+2 cycles
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < QL; i++) p[k][i] = W'((7 + k) % tq[i]);
    in_poly  = p;
    in_valid = 1'b1;
    last_acc = -1;
    nacc     = 0;
    for (cyc = 0; cyc < 4 * (QL + 2); cyc++) begin
      if (in_ready) begin
        exp_q.push_back(model(p));
        if (last_acc >= 0) check("accept_interval", cyc - last_acc, QL + 2);
        last_acc = cyc;
        nacc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("accept_count", nacc, 4);
    repeat (QL + 3) @(negedge clk);

`ifdef FBC_Q2BBA_BACKPRESSURE_EN
    // out_ready low for 3 DONE cycles: valid and data must hold
    for (int k = 0; k < NS; k++)
      for (int i = 0; i < QL; i++) p[k][i] = W'((11 + 2 * k + i) % tq[i]);
    out_ready = 1'b0;
    send_wait(p, 1'b1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_poly", out_poly, model(p));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_released", out_valid, 0);
`endif

    nov = 0;
    while (exp_q.size() != 0 && nov < 100) begin @(negedge clk); nov++; end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
